exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter VECTOR_ADDR, default 64'h0000_0000_0000_00D8, handler entry address driven on every exception redirect.
REQ-002 Parameter PC_W, default 64, width of all PC and ELR signals.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq_raw  in  1  asynchronous external interrupt request, level-sensitive.
REQ-006 Exc  in  1  exception taken this cycle, from main decoder.
REQ-007 EStatus  in  4  cause code from decoder: 4'b0001 IRQ, 4'b0010 undefined instruction.
REQ-008 ERet  in  1  ERET in execute stage, from decoder.
REQ-009 PC_EX  in  PC_W  PC of instruction currently in execute.
REQ-010 SysRegSel  in  2  MRS source select: 0 ELR, 1 ESR, 2 state word.
REQ-011 ExtIRQ  out  1  masked interrupt request to main decoder.
REQ-012 PCRedirect  out  1  one-cycle pulse: fetch takes RedirectPC.
REQ-013 RedirectPC  out  PC_W  target for PCRedirect.
REQ-014 FlushPipe  out  1  squash fetch/decode stages, same cycle as PCRedirect.
REQ-015 ELR  out  PC_W  saved return address; ESR  out  4  saved cause.
REQ-016 SysRegData  out  PC_W  MRS read data, combinational from SysRegSel.
REQ-017 Halt  out  1  core stop after double fault, sticky.

Function
REQ-018 FSM states RUN, HANDLER, LOCKUP; encoding 2 bits.
REQ-019 irq_raw passes a 2-flop synchronizer; latency irq_raw to ExtIRQ is 2 cycles when unmasked.
REQ-020 ExtIRQ = synchronized IRQ AND state==RUN AND NOT PCRedirect.
REQ-021 RUN, Exc=1: next cycle state HANDLER, ESR<=EStatus, PCRedirect=1, RedirectPC=VECTOR_ADDR, FlushPipe=1.
REQ-022 ELR capture: EStatus 4'b0001 -> ELR<=PC_EX; 4'b0010 -> ELR<=PC_EX+4; other codes -> ELR<=PC_EX+4, ESR<=EStatus.
REQ-023 PCRedirect/FlushPipe are combinational from the capture event, asserted in the same cycle Exc is sampled high, low otherwise except REQ-025.
REQ-024 RUN, ERet=1, Exc=0: ignored, no redirect, no state change.
REQ-025 HANDLER, ERet=1, Exc=0: PCRedirect=1, RedirectPC=ELR, FlushPipe=1; next state RUN; ELR/ESR retained.
REQ-026 HANDLER, Exc=1 (any cause, including simultaneous ERet): next state LOCKUP, Halt=1, no redirect, ELR/ESR frozen.
REQ-027 LOCKUP: all inputs ignored except reset; Halt stays 1.
REQ-028 RUN, Exc and ERet both 1: exception wins (REQ-021).
REQ-029 PC+4 wraps modulo 2^PC_W.
REQ-030 SysRegData: sel 0 ELR; sel 1 ESR zero-extended; sel 2 {state, Halt} zero-extended; sel 3 zero.

Reset
REQ-031 reset has priority over all events: state RUN, ELR=0, ESR=0, synchronizer flops 0, pending 0, Halt=0, PCRedirect=0, FlushPipe=0, ExtIRQ=0.
REQ-032 reset asserted mid-handler or in LOCKUP returns to RUN with REQ-031 values next cycle.

Configuration
REQ-033 Macro IRQ_PENDING_EN defined: a synchronized irq rising edge while not in RUN sets a pending flop; pending ORs into ExtIRQ on return to RUN and clears when Exc with EStatus 4'b0001 is accepted.
REQ-034 Macro undefined: no pending flop; IRQ edges during HANDLER are lost unless irq_raw is still high on return.

Structure
REQ-035 Package exc_pkg holds the state enum, EStatus codes (ESTAT_IRQ, ESTAT_UNDEF), SysRegSel constants.
REQ-036 Sub-module irq_sync (2-flop synchronizer, synchronous reset) instantiated once.

Verification
REQ-037 Undef instr: PC_EX=64'h40, Exc=1, EStatus=0010 -> PCRedirect=1, RedirectPC=64'hD8, next ELR=64'h44, ESR=0010, state HANDLER.
REQ-038 IRQ: irq_raw=1 at cycle 0 -> ExtIRQ=1 at cycle 2; with Exc=1, EStatus=0001, PC_EX=64'h80 -> ELR=64'h80, ExtIRQ=0 in HANDLER.
REQ-039 Return: in HANDLER, ELR=64'h44, ERet=1 -> PCRedirect=1, RedirectPC=64'h44, next state RUN.
REQ-040 Double fault: in HANDLER, Exc=1 -> Halt=1, ELR/ESR unchanged, reset -> Halt=0, state RUN.
REQ-041 Wrap: PC_EX=64'hFFFF_FFFF_FFFF_FFFC, undef -> ELR=0.
REQ-042 With IRQ_PENDING_EN: irq pulse of 3 cycles during HANDLER, then ERet -> ExtIRQ=1 the cycle after returning to RUN; without macro -> ExtIRQ stays 0.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// State encoding is architecturally visible through the MRS state word.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_LOCKUP  = 2'd2
  } state_e;

  localparam logic [3:0] ESTAT_IRQ   = 4'b0001;
  localparam logic [3:0] ESTAT_UNDEF = 4'b0010;

  localparam logic [1:0] SEL_ELR   = 2'd0;
  localparam logic [1:0] SEL_ESR   = 2'd1;
  localparam logic [1:0] SEL_STATE = 2'd2;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the asynchronous interrupt request line.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller: RUN/HANDLER/LOCKUP FSM, ELR/ESR capture, redirect.
// Optional macro IRQ_PENDING_EN latches IRQ edges seen outside RUN.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned     PC_W        = 64,
  parameter logic [PC_W-1:0] VECTOR_ADDR = PC_W'(64'h0000_0000_0000_00D8)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            irq_raw,
  input  logic            Exc,
  input  logic [3:0]      EStatus,
  input  logic            ERet,
  input  logic [PC_W-1:0] PC_EX,
  input  logic [1:0]      SysRegSel,
  output logic            ExtIRQ,
  output logic            PCRedirect,
  output logic [PC_W-1:0] RedirectPC,
  output logic            FlushPipe,
  output logic [PC_W-1:0] ELR,
  output logic [3:0]      ESR,
  output logic [PC_W-1:0] SysRegData,
  output logic            Halt
);

  state_e          r_state;
  logic [PC_W-1:0] r_elr;
  logic [3:0]      r_esr;
  logic            r_halt;

  logic w_irq_sync;
  logic w_irq_req;
  logic w_take_exc;
  logic w_take_eret;

  irq_sync u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (irq_raw),
    .o_sync  (w_irq_sync)
  );

  // Redirects are decoded combinationally; reset suppresses them in the same cycle.
  assign w_take_exc  = ~reset & (r_state == ST_RUN) & Exc;
  assign w_take_eret = ~reset & (r_state == ST_HANDLER) & ERet & ~Exc;

  assign PCRedirect = w_take_exc | w_take_eret;
  assign FlushPipe  = PCRedirect;
  assign RedirectPC = w_take_exc  ? VECTOR_ADDR :
                      w_take_eret ? r_elr       : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_elr   <= '0;
      r_esr   <= '0;
      r_halt  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (Exc) begin
            r_state <= ST_HANDLER;
            r_esr   <= EStatus;
            r_elr   <= (EStatus == ESTAT_IRQ) ? PC_EX : PC_EX + PC_W'(4);
          end
        end
        ST_HANDLER: begin
          if (Exc) begin
            r_state <= ST_LOCKUP;
            r_halt  <= 1'b1;
          end else if (ERet) begin
            r_state <= ST_RUN;
          end
        end
        ST_LOCKUP: begin
          r_halt <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef IRQ_PENDING_EN
  logic r_irq_q;
  logic r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_irq_q <= w_irq_sync;
      if (w_take_exc && (EStatus == ESTAT_IRQ)) begin
        r_pending <= 1'b0;
      end else if (w_irq_sync && !r_irq_q && (r_state != ST_RUN)) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_irq_req = w_irq_sync | r_pending;
`else
  assign w_irq_req = w_irq_sync;
`endif

  assign ExtIRQ = ~reset & w_irq_req & (r_state == ST_RUN) & ~PCRedirect;

  assign ELR  = r_elr;
  assign ESR  = r_esr;
  assign Halt = r_halt;

  always_comb begin
    SysRegData = '0;
    case (SysRegSel)
      SEL_ELR:   SysRegData = r_elr;
      SEL_ESR:   SysRegData = PC_W'(r_esr);
      SEL_STATE: SysRegData = PC_W'({r_state, r_halt});
      default:   SysRegData = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl; honours IRQ_PENDING_EN.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_raw;
  logic        Exc;
  logic [3:0]  EStatus;
  logic        ERet;
  logic [63:0] PC_EX;
  logic [1:0]  SysRegSel;
  logic        ExtIRQ;
  logic        PCRedirect;
  logic [63:0] RedirectPC;
  logic        FlushPipe;
  logic [63:0] ELR;
  logic [3:0]  ESR;
  logic [63:0] SysRegData;
  logic        Halt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  exception_ctrl #(
    .PC_W        (64),
    .VECTOR_ADDR (64'h0000_0000_0000_00D8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_raw    (irq_raw),
    .Exc        (Exc),
    .EStatus    (EStatus),
    .ERet       (ERet),
    .PC_EX      (PC_EX),
    .SysRegSel  (SysRegSel),
    .ExtIRQ     (ExtIRQ),
    .PCRedirect (PCRedirect),
    .RedirectPC (RedirectPC),
    .FlushPipe  (FlushPipe),
    .ELR        (ELR),
    .ESR        (ESR),
    .SysRegData (SysRegData),
    .Halt       (Halt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // State word is {state[1:0], Halt}: RUN=0, HANDLER=2, LOCKUP+Halt=5.
  task automatic check_sys(input string tag, input logic [1:0] sel, input logic [63:0] exp);
    SysRegSel = sel;
    #1;
    check_eq(tag, SysRegData, exp);
  endtask

  initial begin
    reset = 1'b1; irq_raw = 1'b0; Exc = 1'b0; EStatus = 4'd0;
    ERet = 1'b0; PC_EX = '0; SysRegSel = 2'd0;
    tick(); tick();
    #1;
    check_eq("rst_elr", ELR, 64'h0);
    check_eq("rst_esr", {60'd0, ESR}, 64'h0);
    check_eq("rst_halt", {63'd0, Halt}, 64'h0);
    check_eq("rst_redir", {62'd0, PCRedirect, FlushPipe}, 64'h0);
    check_eq("rst_extirq", {63'd0, ExtIRQ}, 64'h0);
    check_sys("rst_state", 2'd2, 64'h0);
    reset = 1'b0;
    tick();

    // Undefined instruction
    PC_EX = 64'h40; EStatus = 4'b0010; Exc = 1'b1;
    #1;
    check_eq("undef_redir", {62'd0, PCRedirect, FlushPipe}, 64'h3);
    check_eq("undef_target", RedirectPC, 64'hD8);
    tick();
    Exc = 1'b0;
    check_eq("undef_elr", ELR, 64'h44);
    check_eq("undef_esr", {60'd0, ESR}, 64'h2);
    check_sys("undef_state", 2'd2, 64'h2);
    check_sys("undef_sys_esr", 2'd1, 64'h2);
    check_sys("undef_sys_elr", 2'd0, 64'h44);
    check_sys("sys_sel3", 2'd3, 64'h0);

    // Return from handler
    ERet = 1'b1;
    #1;
    check_eq("eret_redir", {62'd0, PCRedirect, FlushPipe}, 64'h3);
    check_eq("eret_target", RedirectPC, 64'h44);
    tick();
    ERet = 1'b0;
    check_sys("eret_state", 2'd2, 64'h0);
    check_eq("eret_elr_kept", ELR, 64'h44);

    // ERET in RUN is ignored
    ERet = 1'b1;
    #1;
    check_eq("run_eret_noredir", {63'd0, PCRedirect}, 64'h0);
    tick();
    ERet = 1'b0;
    check_sys("run_eret_state", 2'd2, 64'h0);

    // PC+4 wraps
    PC_EX = 64'hFFFF_FFFF_FFFF_FFFC; EStatus = 4'b0010; Exc = 1'b1;
    tick();
    Exc = 1'b0;
    check_eq("wrap_elr", ELR, 64'h0);
    ERet = 1'b1; tick(); ERet = 1'b0;

    // Unknown cause code: PC+4, cause recorded verbatim
    PC_EX = 64'h100; EStatus = 4'h5; Exc = 1'b1;
    tick();
    Exc = 1'b0;
    check_eq("other_elr", ELR, 64'h104);
    check_eq("other_esr", {60'd0, ESR}, 64'h5);
    ERet = 1'b1; tick(); ERet = 1'b0;

    // Exc and ERET together in RUN: exception wins
    PC_EX = 64'h200; EStatus = 4'b0010; Exc = 1'b1; ERet = 1'b1;
    #1;
    check_eq("both_target", RedirectPC, 64'hD8);
    tick();
    Exc = 1'b0; ERet = 1'b0;
    check_eq("both_elr", ELR, 64'h204);
    check_sys("both_state", 2'd2, 64'h2);

    // Double fault -> LOCKUP
    PC_EX = 64'h300; EStatus = 4'b0001; Exc = 1'b1; ERet = 1'b1;
    #1;
    check_eq("dbl_noredir", {62'd0, PCRedirect, FlushPipe}, 64'h0);
    tick();
    check_eq("dbl_halt", {63'd0, Halt}, 64'h1);
    check_eq("dbl_elr_frozen", ELR, 64'h204);
    check_eq("dbl_esr_frozen", {60'd0, ESR}, 64'h2);
    check_sys("dbl_state", 2'd2, 64'h5);
    tick();
    check_eq("lock_noredir", {63'd0, PCRedirect}, 64'h0);
    check_eq("lock_halt", {63'd0, Halt}, 64'h1);
    check_eq("lock_elr", ELR, 64'h204);
    Exc = 1'b0; ERet = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("lock_rst_halt", {63'd0, Halt}, 64'h0);
    check_eq("lock_rst_elr", ELR, 64'h0);
    check_sys("lock_rst_state", 2'd2, 64'h0);

    // IRQ synchronizer latency and masking
    irq_raw = 1'b1;
    #1;
    check_eq("irq_c0", {63'd0, ExtIRQ}, 64'h0);
    tick();
    check_eq("irq_c1", {63'd0, ExtIRQ}, 64'h0);
    tick();
    check_eq("irq_c2", {63'd0, ExtIRQ}, 64'h1);
    PC_EX = 64'h80; EStatus = 4'b0001; Exc = 1'b1;
    #1;
    check_eq("irq_take_mask", {63'd0, ExtIRQ}, 64'h0);
    tick();
    Exc = 1'b0;
    check_eq("irq_elr", ELR, 64'h80);
    check_eq("irq_esr", {60'd0, ESR}, 64'h1);
    check_eq("irq_handler_mask", {63'd0, ExtIRQ}, 64'h0);
    irq_raw = 1'b0;
    tick(); tick(); tick();
    ERet = 1'b1; tick(); ERet = 1'b0;
    #1;
    check_eq("irq_after_ret", {63'd0, ExtIRQ}, 64'h0);

    // IRQ pulse entirely inside the handler
    PC_EX = 64'h40; EStatus = 4'b0010; Exc = 1'b1;
    tick();
    Exc = 1'b0;
    tick();
    irq_raw = 1'b1;
    tick(); tick(); tick();
    irq_raw = 1'b0;
    tick(); tick(); tick();
    check_eq("pend_in_handler", {63'd0, ExtIRQ}, 64'h0);
    ERet = 1'b1;
    #1;
    check_eq("pend_eret_cycle", {63'd0, ExtIRQ}, 64'h0);
    tick();
    ERet = 1'b0;
    #1;
`ifdef IRQ_PENDING_EN
    check_eq("pend_after_ret", {63'd0, ExtIRQ}, 64'h1);
`else
    check_eq("pend_after_ret", {63'd0, ExtIRQ}, 64'h0);
`endif
    // Accepting the IRQ consumes any pending request
    PC_EX = 64'h500; EStatus = 4'b0001; Exc = 1'b1;
    tick();
    Exc = 1'b0;
    check_eq("pend_take_elr", ELR, 64'h500);
    ERet = 1'b1; tick(); ERet = 1'b0;
    #1;
    check_eq("pend_cleared", {63'd0, ExtIRQ}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
